// File: rtl/bp_gshare_btb.sv
// Branch predictor for fetch: direct-mapped BTB for targets plus a PHT of saturating counters with optional gshare indexing.
// Lookup is combinational (0 cycles). An update written at a clock edge is visible to lookups from the next cycle on.
// No backpressure: while the post-reset clear walk runs, init_busy is high and resolved-branch updates are dropped.
module bp_gshare_btb #(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 7,
  parameter int TAG_W  = ADDR_W - IDX_W - 2,
  parameter int CTR_W  = 2,
  parameter int GHR_W  = 0,
  localparam int HIST_W = (GHR_W > 0) ? GHR_W : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pred_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  output logic [HIST_W-1:0] pred_ghr,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic [HIST_W-1:0] upd_ghr,
  output logic              init_busy
);

  localparam int ENTRIES = 2 ** IDX_W;
  localparam int TGT_W   = ADDR_W - 2;

  // Counter encodings: weak not-taken sits just below the MSB threshold, weak taken just above.
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1 << (CTR_W - 1));
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_MIN = '0;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  clr_ptr;
  logic [HIST_W-1:0] ghr;
  logic [HIST_W-1:0] ghr_shift;

  logic              btb_valid [ENTRIES];
  logic [TAG_W-1:0]  btb_tag   [ENTRIES];
  logic [TGT_W-1:0]  btb_tgt   [ENTRIES];
  logic [CTR_W-1:0]  pht       [ENTRIES];

  logic              ready;
  logic              upd_en;
  logic              upd_hit;
  logic [CTR_W-1:0]  pht_cur;
  logic [CTR_W-1:0]  pht_nxt;

  logic [IDX_W-1:0]  lk_bidx;
  logic [IDX_W-1:0]  lk_hist;
  logic [IDX_W-1:0]  lk_pidx;
  logic [TAG_W-1:0]  lk_tag;
  logic [IDX_W-1:0]  up_bidx;
  logic [IDX_W-1:0]  up_hist;
  logic [IDX_W-1:0]  up_pidx;
  logic [TAG_W-1:0]  up_tag;

  // Word-offset bits never take part in indexing, tagging or target storage.
  logic unused_bits;
  assign unused_bits = ^{pred_pc[1:0], upd_pc[1:0], upd_target[1:0], upd_ghr, ghr};

  assign ready     = (state == ST_READY) && !rst;
  assign init_busy = !ready;
  assign upd_en    = upd_valid && ready;

  assign lk_bidx = pred_pc[IDX_W+1:2];
  assign lk_tag  = pred_pc[ADDR_W-1:IDX_W+2];
  assign up_bidx = upd_pc[IDX_W+1:2];
  assign up_tag  = upd_pc[ADDR_W-1:IDX_W+2];

  // History folded onto the index width: zero-extended when short, low bits kept when long.
  generate
    if (GHR_W == 0) begin : g_bimodal
      assign lk_hist   = '0;
      assign up_hist   = '0;
      assign ghr_shift = '0;
    end else begin : g_gshare
      if (GHR_W >= IDX_W) begin : g_trunc
        assign lk_hist = ghr[IDX_W-1:0];
        assign up_hist = upd_ghr[IDX_W-1:0];
      end else begin : g_zext
        assign lk_hist = {{(IDX_W - GHR_W){1'b0}}, ghr};
        assign up_hist = {{(IDX_W - GHR_W){1'b0}}, upd_ghr};
      end
      if (GHR_W > 1) begin : g_shift_n
        assign ghr_shift = {ghr[HIST_W-2:0], upd_taken};
      end else begin : g_shift_1
        assign ghr_shift = upd_taken;
      end
    end
  endgenerate

  assign lk_pidx  = lk_bidx ^ lk_hist;
  assign up_pidx  = up_bidx ^ up_hist;
  assign pred_ghr = ready ? ghr : '0;

  // Fetch-side lookup; all outputs are forced quiet until the tables are cleared.
  always_comb begin
    pred_hit    = 1'b0;
    pred_taken  = 1'b0;
    pred_target = '0;
    if (ready) begin
      pred_hit    = btb_valid[lk_bidx] && (btb_tag[lk_bidx] == lk_tag);
      pred_taken  = pred_hit && pht[lk_pidx][CTR_W-1];
      pred_target = {btb_tgt[lk_bidx], 2'b00};
    end
  end

  // Next PHT value: saturating step, except a fresh taken allocation restarts at weak taken.
  always_comb begin
    upd_hit = btb_valid[up_bidx] && (btb_tag[up_bidx] == up_tag);
    pht_cur = pht[up_pidx];
    pht_nxt = pht_cur;
    if (upd_taken) begin
      if (!upd_hit)
        pht_nxt = CTR_WT;
      else if (pht_cur != CTR_MAX)
        pht_nxt = pht_cur + CTR_W'(1);
    end else if (pht_cur != CTR_MIN) begin
      pht_nxt = pht_cur - CTR_W'(1);
    end
  end

  // Clear walk: one entry per cycle from index 0 upward, restarted by every rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
    end else if (state == ST_CLEAR) begin
      clr_ptr <= clr_ptr + IDX_W'(1);
      if (clr_ptr == IDX_W'(ENTRIES - 1))
        state <= ST_READY;
    end
  end

  // Table writes: the clear walk owns the tables until READY, then resolved branches train them.
  always_ff @(posedge clk) begin
    if (!rst && (state == ST_CLEAR)) begin
      btb_valid[clr_ptr] <= 1'b0;
      pht[clr_ptr]       <= CTR_WNT;
    end else if (upd_en) begin
      pht[up_pidx] <= pht_nxt;
      if (upd_taken) begin
        btb_valid[up_bidx] <= 1'b1;
        btb_tag[up_bidx]   <= up_tag;
        btb_tgt[up_bidx]   <= upd_target[ADDR_W-1:2];
      end
    end
  end

  // Non-speculative global history: shifts only on resolved branches, held at zero while clearing.
  always_ff @(posedge clk) begin
    if (rst || (state == ST_CLEAR))
      ghr <= '0;
    else if (upd_en)
      ghr <= ghr_shift;
  end

endmodule
